// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the fetch and data stages.
// Data wins contention until fetch has lost STARVE_LIMIT contended grants in a row.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no access in flight; arbitrate and latch winner's request
// S_ISSUE | mem_en strobe for the latched access; load wait counter
// S_WAIT  | wait out MEM_LATENCY; capture mem_rdata when counter hits 0
// S_DONE  | owner's valid pulse; always returns to S_IDLE
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_F,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_M,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic              owner_q;
    logic              we_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [STV_W-1:0]  starve_cnt_q;
    logic [STV_W-1:0]  starve_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic              if_valid_q;
    logic              dm_valid_q;
    logic              busy_q;
    logic              any_req;
    logic              grant_dm;

    // Starve count only advances when fetch was actually waiting on a data win.
    always_comb begin
        any_req      = if_req | dm_req;
        grant_dm     = dm_req & ~(if_req & (starve_cnt_q == STV_MAX));
        starve_cnt_d = starve_cnt_q;
        if (!grant_dm) begin
            starve_cnt_d = '0;
        end else if (if_req && (starve_cnt_q != STV_MAX)) begin
            starve_cnt_d = starve_cnt_q + STV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            if_valid_q   <= 1'b0;
            dm_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        owner_q      <= grant_dm;
                        we_q         <= grant_dm & dm_we;
                        starve_cnt_q <= starve_cnt_d;
                        mem_addr_q   <= grant_dm ? dm_addr : if_addr;
                        if (grant_dm) begin
                            mem_wdata_q <= dm_wdata;
                        end
                        mem_en_q     <= 1'b1;
                        mem_we_q     <= grant_dm & dm_we;
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt_q <= CNT_LOAD;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == '0) begin
                        if (!we_q) begin
                            if (owner_q) begin
                                dm_rdata_q <= mem_rdata;
                            end else begin
                                if_rdata_q <= mem_rdata;
                            end
                        end
                        if (owner_q) begin
                            dm_valid_q <= 1'b1;
                        end else begin
                            if_valid_q <= 1'b1;
                        end
                        state_q <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign busy      = busy_q;
    assign stall_F   = if_req & ~if_valid_q;
    assign stall_M   = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut_a (latency 2, starve limit 2), dut_b (latency 1).
// Both instances share the request inputs; each test checks the instance it targets.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] mem_rdata = '0;

    logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata;
    logic        a_if_valid, a_stall_F, a_dm_valid, a_stall_M, a_mem_en, a_mem_we, a_busy;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
    logic        b_if_valid, b_stall_F, b_dm_valid, b_stall_M, b_mem_en, b_mem_we, b_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(2)) dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_valid(a_if_valid),
        .stall_F(a_stall_F),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(a_dm_rdata), .dm_valid(a_dm_valid), .stall_M(a_stall_M),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
        .stall_F(b_stall_F),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(b_dm_rdata), .dm_valid(b_dm_valid), .stall_M(b_stall_M),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Lands 1 time unit after the n-th next rising edge; inputs are driven here.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        adv(2);
        #1;
        chk("rst_busy",     a_busy, 0);
        chk("rst_mem_en",   a_mem_en, 0);
        chk("rst_mem_we",   a_mem_we, 0);
        chk("rst_mem_addr", a_mem_addr, 0);
        chk("rst_wdata",    a_mem_wdata, 0);
        chk("rst_if_valid", a_if_valid, 0);
        chk("rst_dm_valid", a_dm_valid, 0);
        chk("rst_if_rdata", a_if_rdata, 0);
        chk("rst_dm_rdata", a_dm_rdata, 0);
        chk("rst_b_busy",   b_busy, 0);
        rst = 1'b0;
    endtask

    logic [31:0] t4_addr [6] = '{32'hA0, 32'hA0, 32'h50, 32'hA0, 32'hA0, 32'h50};
    logic [1:0]  t4_stv  [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: sim time 200000 reached, bench did not finish");
        $fatal(1);
    end

    initial begin
        adv(1);
        do_reset();

        // Test 1: single fetch read
        adv(1); if_req = 1'b1; if_addr = 32'h40; #1;
        chk("t1_c0_stallF", a_stall_F, 1);
        chk("t1_c0_mem_en", a_mem_en, 0);
        adv(1); #1;
        chk("t1_c1_mem_en", a_mem_en, 1);
        chk("t1_c1_mem_we", a_mem_we, 0);
        chk("t1_c1_addr",   a_mem_addr, 32'h40);
        chk("t1_c1_busy",   a_busy, 1);
        chk("t1_c1_stallF", a_stall_F, 1);
        adv(1); #1;
        chk("t1_c2_mem_en", a_mem_en, 0);
        chk("t1_c2_stallF", a_stall_F, 1);
        adv(1); mem_rdata = 32'h2010FFFF; #1;
        chk("t1_c3_if_valid", a_if_valid, 0);
        chk("t1_c3_stallF", a_stall_F, 1);
        adv(1); #1;
        chk("t1_c4_if_valid", a_if_valid, 1);
        chk("t1_c4_if_rdata", a_if_rdata, 32'h2010FFFF);
        chk("t1_c4_stallF", a_stall_F, 0);
        chk("t1_c4_dm_valid", a_dm_valid, 0);
        if_req = 1'b0;
        adv(1); #1;
        chk("t1_c5_if_valid", a_if_valid, 0);
        chk("t1_c5_busy", a_busy, 0);
        chk("t1_c5_if_rdata_hold", a_if_rdata, 32'h2010FFFF);

        // Test 2: data write
        adv(1); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEADBEEF;
        mem_rdata = 32'h12345678; #1;
        chk("t2_c0_stallM", a_stall_M, 1);
        adv(1); #1;
        chk("t2_c1_mem_en", a_mem_en, 1);
        chk("t2_c1_mem_we", a_mem_we, 1);
        chk("t2_c1_addr",   a_mem_addr, 32'h80);
        chk("t2_c1_wdata",  a_mem_wdata, 32'hDEADBEEF);
        adv(1); #1;
        chk("t2_c2_mem_en", a_mem_en, 0);
        chk("t2_c2_addr_hold", a_mem_addr, 32'h80);
        adv(2); #1;
        chk("t2_c4_dm_valid", a_dm_valid, 1);
        chk("t2_c4_dm_rdata", a_dm_rdata, 32'h0);
        chk("t2_c4_stallM", a_stall_M, 0);
        chk("t2_c4_if_valid", a_if_valid, 0);
        dm_req = 1'b0; dm_we = 1'b0;
        adv(1); #1;
        chk("t2_c5_dm_valid", a_dm_valid, 0);

        // Test 3: contention, data first then fetch
        adv(1); if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_we = 1'b0;
        dm_addr = 32'h90; mem_rdata = 32'hAAAA0001; #1;
        adv(1); #1;
        chk("t3_c1_mem_en", a_mem_en, 1);
        chk("t3_c1_addr",   a_mem_addr, 32'h90);
        adv(3); #1;
        chk("t3_c4_dm_valid", a_dm_valid, 1);
        chk("t3_c4_dm_rdata", a_dm_rdata, 32'hAAAA0001);
        chk("t3_c4_stallF", a_stall_F, 1);
        dm_req = 1'b0; mem_rdata = 32'hBBBB0002;
        adv(1); #1;
        chk("t3_c5_busy", a_busy, 0);
        chk("t3_c5_stallF", a_stall_F, 1);
        adv(1); #1;
        chk("t3_c6_mem_en", a_mem_en, 1);
        chk("t3_c6_addr",   a_mem_addr, 32'h44);
        adv(2); #1;
        chk("t3_c8_stallF", a_stall_F, 1);
        chk("t3_c8_if_valid", a_if_valid, 0);
        adv(1); #1;
        chk("t3_c9_if_valid", a_if_valid, 1);
        chk("t3_c9_if_rdata", a_if_rdata, 32'hBBBB0002);
        chk("t3_c9_stallF", a_stall_F, 0);
        if_req = 1'b0;

        // Test 4: starvation limit 2 with both requesters held
        adv(1); if_req = 1'b1; if_addr = 32'h50; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hA0; #1;
        for (int g = 0; g < 6; g++) begin
            int k;
            k = 0;
            while (a_mem_en !== 1'b1 && k < 12) begin
                adv(1); #1;
                k++;
            end
            chk($sformatf("t4_grant%0d_seen", g), 64'(k < 12), 1);
            chk($sformatf("t4_grant%0d_addr", g), a_mem_addr, t4_addr[g]);
            chk($sformatf("t4_grant%0d_starve", g), dut_a.starve_cnt_q, t4_stv[g]);
            adv(1); #1;
        end
        do_reset();

        // Test 5: reset during WAIT of a fetch
        adv(1); if_req = 1'b1; if_addr = 32'h60; #1;
        adv(1); #1;
        chk("t5_c1_mem_en", a_mem_en, 1);
        adv(1); rst = 1'b1; #1;
        adv(1); rst = 1'b0; mem_rdata = 32'hBAD0BAD0; #1;
        chk("t5_c3_busy", a_busy, 0);
        chk("t5_c3_mem_en", a_mem_en, 0);
        chk("t5_c3_if_valid", a_if_valid, 0);
        adv(1); #1;
        chk("t5_c4_mem_en", a_mem_en, 1);
        chk("t5_c4_addr", a_mem_addr, 32'h60);
        chk("t5_c4_if_rdata", a_if_rdata, 32'h0);
        adv(1); #1;
        chk("t5_c5_if_valid", a_if_valid, 0);
        adv(1); mem_rdata = 32'h600DF00D; #1;
        chk("t5_c6_if_valid", a_if_valid, 0);
        adv(1); #1;
        chk("t5_c7_if_valid", a_if_valid, 1);
        chk("t5_c7_if_rdata", a_if_rdata, 32'h600DF00D);
        if_req = 1'b0;
        do_reset();

        // Test 6: latency 1, back-to-back data reads on dut_b
        adv(1); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10; mem_rdata = 32'h11110010; #1;
        adv(1); #1;
        chk("t6_c1_mem_en", b_mem_en, 1);
        chk("t6_c1_addr", b_mem_addr, 32'h10);
        adv(1); #1;
        chk("t6_c2_mem_en", b_mem_en, 0);
        adv(1); #1;
        chk("t6_c3_dm_valid", b_dm_valid, 1);
        chk("t6_c3_dm_rdata", b_dm_rdata, 32'h11110010);
        dm_addr = 32'h14;
        adv(1); #1;
        chk("t6_c4_dm_valid", b_dm_valid, 0);
        chk("t6_c4_stallM", b_stall_M, 1);
        adv(1); #1;
        chk("t6_c5_mem_en", b_mem_en, 1);
        chk("t6_c5_addr", b_mem_addr, 32'h14);
        adv(1); mem_rdata = 32'h22220014; #1;
        adv(1); #1;
        chk("t6_c7_dm_valid", b_dm_valid, 1);
        chk("t6_c7_dm_rdata", b_dm_rdata, 32'h22220014);
        chk("t6_c7_if_valid", b_if_valid, 0);
        dm_req = 1'b0;
        adv(1); #1;
        chk("t6_c8_dm_valid", b_dm_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
